// File: rtl/sb_param_cfg.sv
// Purpose: parametrised eFPGA switch block with a shadowed, count-validated config chain.
// Latency: chan_out is combinational (OUT_REG=0) or one prog_clk behind (OUT_REG=1); new selects take effect the cycle after commit.
// Backpressure: none; the chain shifts whenever ccff_en is high and a bad commit only raises the sticky cfg_err.
module sb_param_cfg #(
    parameter int CHAN_W         = 9,
    parameter int FANIN_PER_SIDE = 3,
    parameter int STRIDE         = 4,
    parameter int OUT_REG        = 0,
    localparam int NUM_IN        = 3 * FANIN_PER_SIDE + 1,
    localparam int SEL_BITS      = $clog2(NUM_IN),
    localparam int CFG_BITS      = 4 * CHAN_W * SEL_BITS,
    localparam int CNT_W         = $clog2(CFG_BITS + 1)
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic [4*CHAN_W-1:0] chan_in,
    input  logic [3:0]          grid_opin,
    output logic [4*CHAN_W-1:0] chan_out,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic                cfg_valid,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    cfg_count
);

    localparam logic [CNT_W-1:0] CFG_BITS_C = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [SEL_BITS-1:0] sel [4*CHAN_W];
    logic [4*CHAN_W-1:0] route;
    logic                commit_ok;

    // A commit is only honoured on a quiet chain holding exactly a full frame.
    assign commit_ok = cfg_commit && !ccff_en && (cfg_count == CFG_BITS_C);
    assign ccff_tail = shadow[CFG_BITS-1];

    // Shadow chain, bit counter, active selects and status flags.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shadow    <= '0;
            active    <= '0;
            cfg_count <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (ccff_en) begin
                shadow <= {shadow[CFG_BITS-2:0], ccff_head};
                if (cfg_count != CFG_BITS_C) begin
                    cfg_count <= cfg_count + 1'b1;
                end
            end
            if (commit_ok) begin
                active    <= shadow;
                cfg_count <= '0;
                cfg_valid <= 1'b1;
            end else if (cfg_commit) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Slice the active frame into one select field per outgoing track.
    always_comb begin
        for (int i = 0; i < 4 * CHAN_W; i++) begin
            sel[i] = active[i*SEL_BITS +: SEL_BITS];
        end
    end

    // Per-track mux: grid pin, then FANIN_PER_SIDE strided tracks from each other side; unused codes give 0.
    always_comb begin
        route = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < CHAN_W; t++) begin
                if (int'(sel[s*CHAN_W+t]) == 0) begin
                    route[s*CHAN_W+t] = grid_opin[s];
                end
                for (int j = 0; j < 3; j++) begin
                    for (int k = 0; k < FANIN_PER_SIDE; k++) begin
                        if (int'(sel[s*CHAN_W+t]) == 1 + j * FANIN_PER_SIDE + k) begin
                            route[s*CHAN_W+t] =
                                chan_in[((s + 1 + j) % 4) * CHAN_W + ((t + k * STRIDE) % CHAN_W)];
                        end
                    end
                end
            end
        end
        if (!cfg_valid) begin
            route = '0;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Register the routed value every cycle for a fixed one-cycle output latency.
        always_ff @(posedge prog_clk) begin
            if (prog_reset) begin
                chan_out <= '0;
            end else begin
                chan_out <= route;
            end
        end
    end else begin : g_out_comb
        assign chan_out = route;
    end

endmodule

// File: tb/tb_sb_param_cfg.sv
module tb_sb_param_cfg;

    localparam int CW   = 4;
    localparam int F    = 2;
    localparam int ST   = 1;
    localparam int NIN  = 3 * F + 1;
    localparam int CB   = 48;
    localparam int CNTW = 6;

    logic             prog_clk;
    logic             prog_reset;
    logic [15:0]      chan_in;
    logic [3:0]       grid_opin;
    logic             ccff_head;
    logic             ccff_en;
    logic             cfg_commit;

    logic [15:0]      out0, out1;
    logic             tail0, tail1, valid0, valid1, err0, err1;
    logic [CNTW-1:0]  cnt0, cnt1;

    int n_chk;
    int n_fail;

    sb_param_cfg #(.CHAN_W(CW), .FANIN_PER_SIDE(F), .STRIDE(ST), .OUT_REG(0)) dut0 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .chan_in(chan_in), .grid_opin(grid_opin),
        .chan_out(out0), .ccff_head(ccff_head), .ccff_en(ccff_en), .cfg_commit(cfg_commit),
        .ccff_tail(tail0), .cfg_valid(valid0), .cfg_err(err0), .cfg_count(cnt0));

    sb_param_cfg #(.CHAN_W(CW), .FANIN_PER_SIDE(F), .STRIDE(ST), .OUT_REG(1)) dut1 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .chan_in(chan_in), .grid_opin(grid_opin),
        .chan_out(out1), .ccff_head(ccff_head), .ccff_en(ccff_en), .cfg_commit(cfg_commit),
        .ccff_tail(tail1), .cfg_valid(valid1), .cfg_err(err1), .cfg_count(cnt1));

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Reference model: history of shifted bits (oldest first), decoded select table, flags.
    bit          m_hist[$];
    int          m_sel[16];
    bit          m_valid;
    bit          m_err;
    int          m_cnt;
    logic [15:0] m_out1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_comb(input logic [15:0] ci, input logic [3:0] g);
        logic [15:0] r;
        int s, t, v, j, k;
        r = '0;
        if (!m_valid) return r;
        for (int i = 0; i < 16; i++) begin
            s = i / CW;
            t = i % CW;
            v = m_sel[i];
            if (v == 0) begin
                r[i] = g[s];
            end else if (v < NIN) begin
                j = (v - 1) / F;
                k = (v - 1) % F;
                r[i] = ci[((s + 1 + j) % 4) * CW + ((t + k * ST) % CW)];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        repeat (CB) m_hist.push_back(1'b0);
        for (int i = 0; i < 16; i++) m_sel[i] = 0;
        m_valid = 0;
        m_err   = 0;
        m_cnt   = 0;
        m_out1  = '0;
    endtask

    task automatic check_all();
        chk("out0",   32'(out0),   32'(model_comb(chan_in, grid_opin)));
        chk("out1",   32'(out1),   32'(m_out1));
        chk("tail0",  32'(tail0),  32'(m_hist[0]));
        chk("tail1",  32'(tail1),  32'(m_hist[0]));
        chk("valid0", 32'(valid0), 32'(m_valid));
        chk("valid1", 32'(valid1), 32'(m_valid));
        chk("err0",   32'(err0),   32'(m_err));
        chk("err1",   32'(err1),   32'(m_err));
        chk("cnt0",   32'(cnt0),   32'(m_cnt));
        chk("cnt1",   32'(cnt1),   32'(m_cnt));
    endtask

    // One clock: predict from pre-edge state/inputs, advance the model, then compare.
    task automatic tick();
        logic [15:0] nxt_out1;
        bit ok;
        int v;
        nxt_out1 = model_comb(chan_in, grid_opin);
        ok = cfg_commit && !ccff_en && (m_cnt == CB);
        @(posedge prog_clk);
        if (prog_reset) begin
            model_reset();
        end else begin
            m_out1 = nxt_out1;
            if (cfg_commit && !ok) m_err = 1;
            if (ok) begin
                for (int i = 0; i < 16; i++) begin
                    v = 0;
                    for (int b = 0; b < 3; b++) v = v | (int'(m_hist[CB-1-(i*3+b)]) << b);
                    m_sel[i] = v;
                end
                m_cnt   = 0;
                m_valid = 1;
            end
            if (ccff_en) begin
                m_hist.push_back(ccff_head);
                void'(m_hist.pop_front());
                if (m_cnt < CB) m_cnt++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic step(input bit en, input bit head, input bit cm);
        ccff_en    = en;
        ccff_head  = head;
        cfg_commit = cm;
        tick();
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic shift_word(input logic [47:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[47-i], 1'b0);
    endtask

    task automatic do_reset();
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
    endtask

    function automatic logic [47:0] all_sel(input int v);
        logic [47:0] w;
        for (int i = 0; i < 16; i++) w[i*3 +: 3] = 3'(v);
        return w;
    endfunction

    typedef struct {
        logic [15:0] ci;
        logic [3:0]  g;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [47:0] w;

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        prog_reset = 1'b1;
        chan_in    = '0;
        grid_opin  = '0;
        ccff_head  = 1'b0;
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
        model_reset();

        // Every select = 1: output side s track t comes from side s+1 track t.
        vecs[0] = '{16'h0010, 4'h0, 16'h0001};
        vecs[1] = '{16'h1234, 4'hF, 16'h4123};
        vecs[2] = '{16'hFFFF, 4'h0, 16'hFFFF};
        vecs[3] = '{16'h8000, 4'h5, 16'h0800};
        vecs[4] = '{16'h0001, 4'hA, 16'h1000};
        vecs[5] = '{16'h0000, 4'hF, 16'h0000};

        // Reset and unconfigured gating.
        tick();
        prog_reset = 1'b0;
        chan_in    = 16'hFFFF;
        grid_opin  = 4'hF;
        tick();
        chk("unconf_out", 32'(out0), 32'h0);
        chk("unconf_valid", 32'(valid0), 32'h0);
        chk("unconf_tail", 32'(tail0), 32'h0);

        // Load all-ones selects and commit.
        shift_word(all_sel(1), CB);
        chk("full_cnt", 32'(cnt0), 32'd48);
        step(1'b0, 1'b0, 1'b1);
        chk("commit_valid", 32'(valid0), 32'h1);
        chk("commit_cnt", 32'(cnt0), 32'h0);

        for (int i = 0; i < 6; i++) begin
            chan_in   = vecs[i].ci;
            grid_opin = vecs[i].g;
            #1;
            chk($sformatf("vec%0d", i), 32'(out0), 32'(vecs[i].exp));
        end

        // Registered copy lags by exactly one cycle.
        chan_in = 16'h0000;
        tick();
        tick();
        chan_in = 16'h0010;
        #1;
        chk("reg_hold", 32'(out1), 32'h0);
        chk("comb_now", 32'(out0), 32'h1);
        tick();
        chk("reg_upd", 32'(out1), 32'h1);

        // Top track 0 from grid_opin[0].
        w = all_sel(1);
        w[2:0] = 3'd0;
        shift_word(w, CB);
        step(1'b0, 1'b0, 1'b1);
        chan_in   = 16'h0000;
        grid_opin = 4'h1;
        #1;
        chk("grid_hi", 32'(out0), 32'h1);
        grid_opin = 4'hE;
        #1;
        chk("grid_lo", 32'(out0), 32'h0);

        // Out-of-range select on top track 0.
        w[2:0] = 3'd7;
        shift_word(w, CB);
        step(1'b0, 1'b0, 1'b1);
        chan_in   = 16'hFFFF;
        grid_opin = 4'hF;
        #1;
        chk("sel7", 32'(out0), 32'hFFFE);

        // Short frame rejected, completed frame accepted; err stays sticky.
        shift_word(all_sel(1), CB);
        step(1'b0, 1'b0, 1'b1);
        chan_in = 16'h0010;
        w = all_sel(2);
        shift_word(w, 47);
        step(1'b0, 1'b0, 1'b1);
        chk("short_err", 32'(err0), 32'h1);
        chk("short_cnt", 32'(cnt0), 32'd47);
        chk("short_keep", 32'(out0), 32'h1);
        step(1'b1, w[0], 1'b0);
        chk("tail_latency", 32'(tail0), 32'(w[47]));
        step(1'b0, 1'b0, 1'b1);
        chk("late_valid", 32'(valid0), 32'h1);
        chk("late_err", 32'(err0), 32'h1);
        chk("late_route", 32'(out0), 32'h8);

        // Commit together with shift is rejected while the shift still happens.
        do_reset();
        shift_word(all_sel(1), CB);
        step(1'b0, 1'b0, 1'b1);
        chk("clean_err", 32'(err0), 32'h0);
        shift_word(all_sel(2), CB);
        step(1'b1, 1'b1, 1'b1);
        chk("both_err", 32'(err0), 32'h1);
        chk("both_cnt", 32'(cnt0), 32'd48);
        chk("both_keep", 32'(out0), 32'h1);
        chk("both_tail", 32'(tail0), 32'h1);
        step(1'b0, 1'b0, 1'b1);

        // Saturation beyond a full frame.
        shift_word(all_sel(3), CB);
        shift_word(all_sel(5), 12);
        chk("sat_cnt", 32'(cnt0), 32'd48);

        // Reset mid-shift.
        shift_word(all_sel(4), 20);
        ccff_en    = 1'b1;
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        ccff_en    = 1'b0;
        chk("rst_out0", 32'(out0), 32'h0);
        chk("rst_out1", 32'(out1), 32'h0);
        chk("rst_cnt", 32'(cnt0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            chan_in    = 16'($urandom);
            grid_opin  = 4'($urandom);
            ccff_head  = 1'($urandom);
            ccff_en    = ($urandom_range(0, 9) < 7);
            cfg_commit = ($urandom_range(0, 19) == 0);
            prog_reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        prog_reset = 1'b0;
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
